nios2_ocimem_debug_port: RTL

Downstream consumer of the debug-slave JTAG wrapper's system-clock outputs: it decodes `jdo` plus the `take_action_ocimem_*` strobes into word accesses on the on-chip debug memory (monitor RAM) and returns read data as `MonDReg` to the wrapper's TCK side. It owns the debug address pointer, auto-increments it per access, sequences a read/write handshake against a stallable memory port, and flags timeouts and dropped commands.

---
 rtl/nios2_ocimem_debug_port.sv | 121 ++++++++++++
 1 files changed

// File: rtl/nios2_ocimem_debug_port.sv
// rtl/nios2_ocimem_debug_port.sv - debug-memory word access sequencer driven by JTAG ocimem strobes
module nios2_ocimem_debug_port #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              access_busy,
  output logic              access_error,
  output logic              cmd_overrun
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                rd_n, wr_n, busy_n, err_n, ovr_n;
  logic [31:0]         wdata_n, mon_n;
  logic                any_strobe;
  logic                unused_jdo_bits;

  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};
  assign any_strobe      = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign mem_address     = ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      MonDReg       <= '0;
      access_busy   <= 1'b0;
      access_error  <= 1'b0;
      cmd_overrun   <= 1'b0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      cnt           <= cnt_n;
      mem_read      <= rd_n;
      mem_write     <= wr_n;
      mem_writedata <= wdata_n;
      MonDReg       <= mon_n;
      access_busy   <= busy_n;
      access_error  <= err_n;
      cmd_overrun   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    wdata_n = mem_writedata;
    mon_n   = MonDReg;
    err_n   = access_error;
    ovr_n   = cmd_overrun;
    case (state)
      IDLE: begin
        // Priority a > b > no_action_a; losers are silently ignored.
        if (take_action_ocimem_a) begin
          ptr_n = jdo[ADDR_W+16:17];
          err_n = 1'b0;
          ovr_n = 1'b0;
          if (jdo[35]) begin
            state_n = READ;
            rd_n    = 1'b1;
            cnt_n   = '0;
          end
        end else if (take_action_ocimem_b) begin
          wdata_n = jdo[34:3];
          state_n = WRITE;
          wr_n    = 1'b1;
          cnt_n   = '0;
        end else if (take_no_action_ocimem_a) begin
          state_n = READ;
          rd_n    = 1'b1;
          cnt_n   = '0;
        end
      end
      READ, WRITE: begin
        if (any_strobe) ovr_n = 1'b1;
        if (!mem_waitrequest) begin
          if (state == READ) mon_n = mem_readdata;
          ptr_n   = ptr + ADDR_W'(1);
          state_n = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          // Abort sample: request is dropped, pointer stays on the failed word.
          err_n = 1'b1;
          if (state == READ) mon_n = 32'hDEAD_DEAD;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          rd_n  = (state == READ);
          wr_n  = (state == WRITE);
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule
